// File: rtl/ace_vram_arbiter_pkg.sv
// Shared constants for the VRAM arbiter: FSM state encodings and the default window.
package ace_vram_arbiter_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int          DEF_AW       = 10;
  localparam logic [15:0] DEF_WIN_BASE = 16'h2400;

  // Window hit: every address bit above the VRAM address width matches the base.
  function automatic logic in_window(input logic [15:0] a, input logic [15:0] base,
                                     input int aw);
    return (a >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/ace_vram_fetch_pipe.sv
// Display fetch return path: tracks a vid_req through the RAM's registered read and
// captures the returned byte two edges after the request was sampled.
module ace_vram_fetch_pipe #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_rvalid
);

  logic [1:0]    r_vld;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_vld    <= {r_vld[0], vid_req};
      r_rvalid <= r_vld[1];
      if (r_vld[1]) r_rdata <= ram_rdata;
    end
  end

  assign vid_rdata  = r_rdata;
  assign vid_rvalid = r_rvalid;

endmodule

// File: rtl/ace_vram_arbiter.sv
// Single-port VRAM arbiter: display fetches own any slot they ask for, CPU accesses
// inside the window take the remaining slots and are stalled with wait_n meanwhile.
module ace_vram_arbiter
  import ace_vram_arbiter_pkg::*;
#(
  parameter int          AW       = DEF_AW,
  parameter logic [15:0] WIN_BASE = DEF_WIN_BASE,
  parameter bit          CONTEND  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   cpu_a,
  input  logic [7:0]    cpu_do,
  input  logic          cpu_mreq_n,
  input  logic          cpu_rd_n,
  input  logic          cpu_wr_n,
  output logic          cpu_wait_n,
  output logic [7:0]    cpu_di,
  output logic          cpu_hit,
  input  logic          vid_active,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_rdata,
  output logic          vid_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [7:0]    r_ram_wdata;
  logic [7:0]    r_cpu_di;
  logic          r_is_wr;
  logic          w_pend;
  logic          w_blocked;
  logic          w_grant;

  assign cpu_hit   = !cpu_mreq_n && in_window(cpu_a, WIN_BASE, AW);
  assign w_pend    = cpu_hit && (!cpu_rd_n || !cpu_wr_n);
  assign w_blocked = CONTEND && vid_active;
  assign w_grant   = !vid_req && w_pend && !w_blocked && (r_state == IDLE || r_state == WAIT);

  // Combinational so the stall is visible before the core samples wait in T2.
  assign cpu_wait_n = reset || !(w_pend && r_state != DONE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_pend) w_state_next = w_grant ? ACCESS : WAIT;
      WAIT:    if (!w_pend) w_state_next = IDLE;
               else if (w_grant) w_state_next = ACCESS;
      ACCESS:  w_state_next = DATA;
      DATA:    w_state_next = w_pend ? DONE : IDLE;
      DONE:    if (cpu_mreq_n) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_cpu_di    <= '0;
      r_is_wr     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (vid_req) begin
        r_ram_addr <= vid_addr;
        r_ram_we   <= 1'b0;
      end else if (w_grant) begin
        r_ram_addr  <= cpu_a[AW-1:0];
        r_ram_we    <= !cpu_wr_n;
        r_ram_wdata <= cpu_do;
        r_is_wr     <= !cpu_wr_n;
      end else begin
        r_ram_we <= 1'b0;
      end
      // Read data is captured even if the strobes dropped mid-access; writes leave it alone.
      if (r_state == DATA && !r_is_wr) r_cpu_di <= ram_rdata;
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign cpu_di    = r_cpu_di;

  ace_vram_fetch_pipe #(.DW(8)) u_fetch_pipe (
    .clk        (clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .ram_rdata  (ram_rdata),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid)
  );

endmodule

// File: tb/tb_ace_vram_arbiter.sv
// Directed bench: instance 0 has CONTEND=0, instance 1 has CONTEND=1; each has its own RAM model.
module tb_ace_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic        vid_active, vid_req;
  logic [9:0]  vid_addr;

  logic [1:0]  wait_n, hit, rvalid, we;
  logic [7:0]  di [2];
  logic [7:0]  vrd [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic [9:0]  addr [2];

  logic [7:0]  mem0 [1024];
  logic [7:0]  mem1 [1024];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ace_vram_arbiter #(.AW(10), .WIN_BASE(16'h2400), .CONTEND(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_wait_n(wait_n[0]), .cpu_di(di[0]), .cpu_hit(hit[0]),
    .vid_active(vid_active), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_rdata(vrd[0]), .vid_rvalid(rvalid[0]),
    .ram_addr(addr[0]), .ram_we(we[0]), .ram_wdata(wdata[0]), .ram_rdata(rdata[0])
  );

  ace_vram_arbiter #(.AW(10), .WIN_BASE(16'h2400), .CONTEND(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_wait_n(wait_n[1]), .cpu_di(di[1]), .cpu_hit(hit[1]),
    .vid_active(vid_active), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_rdata(vrd[1]), .vid_rvalid(rvalid[1]),
    .ram_addr(addr[1]), .ram_we(we[1]), .ram_wdata(wdata[1]), .ram_rdata(rdata[1])
  );

  // Synchronous single-port RAMs, read-first, data one cycle after the address.
  always @(posedge clk) begin
    if (we[0] === 1'b1) mem0[addr[0]] <= wdata[0];
    rdata[0] <= mem0[addr[0]];
    if (we[1] === 1'b1) mem1[addr[1]] <= wdata[1];
    rdata[1] <= mem1[addr[1]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("  ok   %s = %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    cpu_mreq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a);
    cpu_a      = a;
    cpu_mreq_n = 1'b0;
    cpu_rd_n   = 1'b0;
    cpu_wr_n   = 1'b1;
  endtask

  initial begin
    int lows0, lows1, cnt_we, cnt_hi, cnt_v;
    logic [13:0] pat;
    logic        hist [32];
    logic [15:0] t_addr [5];
    logic        t_hit [5];

    bus_idle();
    cpu_a = 16'h0000; cpu_do = 8'h00;
    vid_active = 1'b0; vid_req = 1'b0; vid_addr = '0;
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      mem0[i] <= 8'h00;
      mem1[i] <= 8'h00;
    end
    #1;
    mem0[5] <= 8'hA7;  mem1[5] <= 8'hA7;
    mem0[6] <= 8'h5B;  mem1[6] <= 8'h5B;
    mem0[10'h033] <= 8'hC3;
    for (int i = 0; i < 16; i++) mem0[10'h100 + i] <= 8'(8'h40 + i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst wait_n", 32'(wait_n[1]), 32'h1);
    check("rst cpu_di", 32'(di[1]), 32'h0);
    check("rst ram_we", 32'(we[1]), 32'h0);
    check("rst ram_addr", 32'(addr[1]), 32'h0);
    check("rst ram_wdata", 32'(wdata[1]), 32'h0);
    check("rst vid_rvalid", 32'(rvalid[1]), 32'h0);
    check("rst vid_rdata", 32'(vrd[1]), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Idle video: read 0x2405 then 0x2406; strobes held into DONE must not re-serve.
    bus_read(16'h2405);
    #1;
    check("rd1 wait low same cycle", 32'(wait_n[0]), 32'h0);
    lows0 = 0; lows1 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lows0 += int'(!wait_n[0]);
      lows1 += int'(!wait_n[1]);
    end
    check("rd1 wait clks dut0", 32'(lows0), 32'd2);
    check("rd1 wait clks dut1", 32'(lows1), 32'd2);
    check("rd1 cpu_di", 32'(di[0]), 32'hA7);
    bus_idle();
    @(negedge clk);
    bus_read(16'h2406);
    lows0 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lows0 += int'(!wait_n[0]);
    end
    check("rd2 wait clks", 32'(lows0), 32'd2);
    check("rd2 cpu_di dut0", 32'(di[0]), 32'h5B);
    check("rd2 cpu_di dut1", 32'(di[1]), 32'h5B);
    bus_idle();
    @(negedge clk);

    // CONTEND=1 write 0x27FF <= 0x3C while vid_active is high for 20 clocks
    vid_active = 1'b1;
    cpu_a = 16'h27FF; cpu_do = 8'h3C;
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    cnt_we = 0; cnt_hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt_we += int'(we[1]);
      cnt_hi += int'(wait_n[1]);
    end
    vid_active = 1'b0;
    check("wr no ram_we in active", 32'(cnt_we), 32'd0);
    check("wr wait held in active", 32'(cnt_hi), 32'd0);
    @(negedge clk);
    check("wr ram_we pulse", 32'(we[1]), 32'h1);
    check("wr ram_addr", 32'(addr[1]), 32'h3FF);
    check("wr ram_wdata", 32'(wdata[1]), 32'h3C);
    cnt_we = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cnt_we += int'(we[1]);
    end
    check("wr single pulse", 32'(cnt_we), 32'd0);
    check("wr wait released", 32'(wait_n[1]), 32'h1);
    check("wr ram content", 32'(mem1[10'h3FF]), 32'h3C);
    check("wr cpu_di unchanged", 32'(di[1]), 32'h5B);
    bus_idle();
    @(negedge clk);

    // CONTEND=0, alternating then back-to-back vid_req, CPU read 0x2433 pending
    vid_active = 1'b1;
    pat = 14'b0000_1111_010101;
    cnt_hi = 0; cnt_we = 0;
    for (int n = 0; n < 17; n++) begin
      if (n >= 3) begin
        check($sformatf("vid rvalid n%0d", n), 32'(rvalid[0]), 32'(hist[n-3]));
        if (hist[n-3]) check($sformatf("vid rdata n%0d", n), 32'(vrd[0]), 32'(8'h40 + n - 3));
      end
      if (n == 1) begin
        check("alt ram_addr video slot", 32'(addr[0]), 32'h100);
        check("alt wait in video slot", 32'(wait_n[0]), 32'h0);
      end
      if (n == 2) begin
        check("alt cpu grant addr", 32'(addr[0]), 32'h033);
        check("alt cpu grant we", 32'(we[0]), 32'h0);
      end
      if (n == 4) begin
        check("alt wait released", 32'(wait_n[0]), 32'h1);
        check("alt cpu_di", 32'(di[0]), 32'hC3);
      end
      if (n > 0) begin
        cnt_hi += int'(wait_n[1]);
        cnt_we += int'(we[1]);
      end
      vid_req  = (n < 14) ? pat[n] : 1'b0;
      vid_addr = 10'(10'h100 + n);
      hist[n]  = vid_req;
      if (n == 0) bus_read(16'h2433);
      @(negedge clk);
    end
    check("contend dut1 stalled", 32'(cnt_hi), 32'd0);
    check("contend dut1 no we", 32'(cnt_we), 32'd0);

    // Abort in WAIT: dut1 never got a slot
    bus_idle();
    #1;
    check("abort wait_n", 32'(wait_n[1]), 32'h1);
    @(negedge clk);
    vid_active = 1'b0;
    cnt_we = 0; cnt_hi = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cnt_we += int'(we[1]);
      cnt_hi += int'(!wait_n[1]);
    end
    check("abort no ram_we", 32'(cnt_we), 32'd0);
    check("abort wait stays high", 32'(cnt_hi), 32'd0);
    check("abort cpu_di unchanged", 32'(di[1]), 32'h5B);

    // Window decode boundaries (no rd/wr strobe, so no stall)
    t_addr = '{16'h2400, 16'h27FF, 16'h23FF, 16'h2800, 16'h1000};
    t_hit  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cpu_a = t_addr[i]; cpu_mreq_n = 1'b0;
      #1;
      check($sformatf("hit %0h", t_addr[i]), 32'(hit[0]), 32'(t_hit[i]));
      check($sformatf("hit wait %0h", t_addr[i]), 32'(wait_n[0]), 32'h1);
      @(negedge clk);
    end
    cpu_a = 16'h2400; cpu_mreq_n = 1'b1;
    #1;
    check("hit needs mreq", 32'(hit[0]), 32'h0);
    @(negedge clk);

    // Miss read of 0x1000
    bus_read(16'h1000);
    #1;
    check("miss hit", 32'(hit[0]), 32'h0);
    cnt_we = 0; cnt_hi = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cnt_we += int'(we[0]);
      cnt_hi += int'(!wait_n[0]);
    end
    check("miss no ram_we", 32'(cnt_we), 32'd0);
    check("miss no wait", 32'(cnt_hi), 32'd0);
    check("miss cpu_di unchanged", 32'(di[0]), 32'hC3);
    bus_idle();
    @(negedge clk);

    // Reset while in DATA with a display fetch in flight
    bus_read(16'h2405);
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 10'h105;
    @(negedge clk);
    vid_req = 1'b0;
    reset = 1'b1;
    #1;
    check("rst-data wait_n", 32'(wait_n[0]), 32'h1);
    check("rst-data ram_we", 32'(we[0]), 32'h0);
    check("rst-data ram_addr", 32'(addr[0]), 32'h0);
    check("rst-data cpu_di", 32'(di[0]), 32'h0);
    check("rst-data vid_rvalid", 32'(rvalid[0]), 32'h0);
    bus_idle();
    #1;
    reset = 1'b0;
    cnt_v = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cnt_v += int'(rvalid[0]);
    end
    check("rst-data flushed fetch", 32'(cnt_v), 32'd0);
    check("rst-data idle wait_n", 32'(wait_n[0]), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ace_vram_arbiter.md
Name: ace_vram_arbiter

Overview:
- Memory-side neighbour of the negedge-strobed Z80 core wrapper.
- Consumes the core's bus strobes and address/data, and arbitrates a single-port synchronous video RAM between CPU accesses and display fetches.
- Produces the core's wait_n and read data for accesses that hit the VRAM window.
- Display fetches always have priority; the CPU is stalled with wait_n until it is granted a free slot.

Parameters:
- AW, 10, VRAM address width (window size 2^AW bytes).
- WIN_BASE, 16'h2400, window base; an address hits when cpu_a[15:AW] == WIN_BASE[15:AW].
- CONTEND, 1, 1 => CPU is blocked for the whole of vid_active; 0 => CPU yields only to cycles with vid_req=1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_a  in  16  CPU address bus.
- cpu_do  in  8  CPU write data.
- cpu_mreq_n  in  1  memory request strobe from the core wrapper.
- cpu_rd_n  in  1  read strobe from the core wrapper.
- cpu_wr_n  in  1  write strobe from the core wrapper.
- cpu_wait_n  out  1  wait to the core; low stalls the bus cycle.
- cpu_di  out  8  read data hold register for CPU.
- cpu_hit  out  1  combinational window decode; the system mux selects cpu_di when high.
- vid_active  in  1  display-active interval from the video timing block.
- vid_req  in  1  single-cycle display fetch request.
- vid_addr  in  AW  display fetch address.
- vid_rdata  out  8  display fetch data.
- vid_rvalid  out  1  one-cycle pulse marking vid_rdata valid.
- ram_addr  out  AW  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  8  registered RAM write data.
- ram_rdata  in  8  RAM data; valid one cycle after ram_addr/ram_we are registered.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; cpu_wait_n=1; cpu_di=0; vid_rdata=0; vid_rvalid=0.
  - ram_we=0; ram_addr=0; ram_wdata=0.
  - Internal fetch pipeline is flushed; an in-flight fetch produces no vid_rvalid.
- Request decode:
  - cpu_hit = !cpu_mreq_n && address in window.
  - pend = cpu_hit && (!cpu_rd_n || !cpu_wr_n).
- Wait output (combinational):
  - cpu_wait_n = !(pend && state != DONE).
  - Wait is driven low in the same cycle the strobe becomes visible, before the core samples it in T2.
- Slot rule, evaluated at each edge:
  - vid_req=1 => ram_addr<=vid_addr, ram_we<=0.
  - Else if state in {IDLE, WAIT} and pend and !(CONTEND && vid_active) => CPU granted: ram_addr<=cpu_a[AW-1:0], ram_we<=!cpu_wr_n, ram_wdata<=cpu_do.
  - Else ram_we<=0.
  - Video and CPU never own the same slot.
- FSM transitions:
  - IDLE: pend and granted -> ACCESS; pend and not granted -> WAIT.
  - WAIT: granted -> ACCESS; !pend (cycle aborted, no RAM access made) -> IDLE.
  - ACCESS: ram_we drops next edge -> DATA.
  - DATA: cpu_di<=ram_rdata (reads only; writes leave cpu_di unchanged) -> DONE.
  - DONE: cpu_wait_n=1; hold until cpu_mreq_n=1, then -> IDLE.
- A new bus cycle is never re-served from DONE: the state must pass through IDLE, which needs mreq_n high for at least 1 clk.
- Strobes that drop during ACCESS/DATA: the RAM op completes, then the FSM goes to IDLE.
- CPU latency with a free RAM: wait is low for 2 clks (IDLE->ACCESS edge, ACCESS, DATA); released in DONE.
- Video pipeline: vid_req sampled at edge k -> ram_rdata valid after k+1 -> at edge k+2, vid_rdata<=ram_rdata and vid_rvalid=1 for one cycle.
- Back-to-back vid_req every cycle is supported at full throughput.
- With vid_req held continuously the CPU waits indefinitely; there is no watchdog.
- Window misses: cpu_wait_n=1 and the FSM stays in IDLE.

Decomposition:
- Shared include file holds:
  - FSM state localparams IDLE=0, WAIT=1, ACCESS=2, DATA=3, DONE=4 (3-bit).
  - Default window constants.
- Optional sub-module ace_vram_fetch_pipe: 2-stage vid_req valid/data pipeline with flush on reset.
- All remaining logic stays in one module.

Test Plan:
- Idle video (vid_active=0, vid_req=0), CPU read 0x2405 with RAM[5]=0xA7 -> wait_n low exactly 2 clks; cpu_di=0xA7 in DONE; return to IDLE after mreq_n rises.
- CPU write 0x27FF data 0x3C with CONTEND=1, vid_active=1 for 20 clks -> no ram_we during vid_active; single ram_we pulse at ram_addr=0x3FF, ram_wdata=0x3C, 1 clk after vid_active falls.
- CONTEND=0, vid_req on alternate cycles, CPU read pending -> CPU granted in the first vid_req=0 slot; every vid_req yields vid_rvalid exactly 2 clks later with correct data.
- CPU read to 0x1000 (miss) -> cpu_hit=0, wait_n stays 1, no RAM activity.
- Assert reset while in DATA -> outputs immediately at reset values (wait_n=1, ram_we=0, vid_rvalid=0); no vid_rvalid from a fetch in flight.
- Bus cycle aborted in WAIT (mreq_n high before grant) -> FSM returns to IDLE; no ram_we, cpu_di unchanged.
